seg_scan_mux: RTL and testbench

//  Downstream of the time-of-day counter/decoder: takes its six 7-bit segment patterns
//  (HH:MM:SS, digit 0 = seconds units) and drives one shared segment bus with

---
 rtl/clock_pkg.sv | 19 +
 rtl/seg_blink_timer.sv | 50 +++++
 rtl/seg_scan_mux.sv | 191 +++++++++++++++++++
 tb/tb_seg_scan_mux.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day display path: idle bus values,
// digit count, scan state encoding and the one-hot digit-enable helper.
package clock_pkg;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [5:0] DIG_OFF    = 6'h3F;
    localparam int         NUM_DIGITS = 6;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    // Active-low enable with only the selected digit pulled low
    function automatic logic [5:0] digit_enable_n(input logic [2:0] idx);
        return ~(6'b000001 << idx);
    endfunction

endpackage

// File: rtl/seg_blink_timer.sv
// Counts frame starts and flips the blink phase every BLINK_FRAMES frames.
module seg_blink_timer
    import clock_pkg::*;
#(
    parameter int BLINK_FRAMES = 83,
    parameter int CNT_W        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick_i,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic             blink_phase_o
);

    logic [CNT_W-1:0] frame_cnt_q;
    logic [CNT_W-1:0] frame_cnt_d;
    logic             blink_phase_q;
    logic             blink_phase_d;

    // Advance the frame counter on each frame start; toggle phase on wrap
    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_tick_i) begin
            if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d   = {CNT_W{1'b0}};
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d   = frame_cnt_q + CNT_W'(1);
            end
        end else begin
            frame_cnt_d   = frame_cnt_q;
        end
    end

    // Counter and phase registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_cnt_q   <= {CNT_W{1'b0}};
            blink_phase_q <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign frame_cnt_o   = frame_cnt_q;
    assign blink_phase_o = blink_phase_q;

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed driver for six 7-segment digits on one shared bus, with
// per-slot blanking, 16-level PWM dimming, per-digit blink and inputs
// captured once per frame so a frame never mixes old and new values.
module seg_scan_mux
    import clock_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCAN_HZ      = 1_000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_FRAMES = 83
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_in0,
    input  logic [6:0] seg_in1,
    input  logic [6:0] seg_in2,
    input  logic [6:0] seg_in3,
    input  logic [6:0] seg_in4,
    input  logic [6:0] seg_in5,
    input  logic       disp_en,
    input  logic [3:0] brightness,
    input  logic [5:0] blink_mask,
    output logic [6:0] seg_out,
    output logic [5:0] dig_en_n,
    output logic       frame_start
);

    localparam int DWELL   = CLK_HZ / SCAN_HZ;
    localparam int SLOT_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // A slot needs at least one dark cycle and at least one drive cycle
    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DWELL) begin : g_bad_blank
        $error("seg_scan_mux: BLANK_CYCLES must lie in 1..DWELL-1");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("seg_scan_mux: BLINK_FRAMES must be at least 1");
    end

    localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(DWELL - 1);
    localparam logic [2:0]        LAST_DIGIT = 3'(NUM_DIGITS - 1);

    scan_state_e       state_q, state_d;
    logic [2:0]        digit_idx_q, digit_idx_d;
    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [3:0]        pwm_cnt_q, pwm_cnt_d;
    logic              first_q;
    logic              frame_tick_s;

    logic [6:0]        shadow_q [NUM_DIGITS];
    logic              disp_en_sh_q;
    logic [3:0]        brightness_sh_q;
    logic [5:0]        blink_mask_sh_q;

    logic              blink_phase_s;
    logic [FRAME_W-1:0] unused_frame_cnt_s;

    logic [6:0]        shadow_sel_s;
    logic              lit_s;
    logic [6:0]        seg_out_q, seg_out_d;
    logic [5:0]        dig_en_n_q, dig_en_n_d;
    logic              frame_start_q;

    seg_blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES),
        .CNT_W        (FRAME_W)
    ) u_blink (
        .clk           (clk),
        .reset         (reset),
        .frame_tick_i  (frame_tick_s),
        .frame_cnt_o   (unused_frame_cnt_s),
        .blink_phase_o (blink_phase_s)
    );

    // Slot sequencer: BLANK then DRIVE per digit; the first edge after reset
    // release counts as entering digit 0's BLANK so a frame starts at once
    always_comb begin
        state_d      = state_q;
        digit_idx_d  = digit_idx_q;
        slot_cnt_d   = slot_cnt_q + SLOT_W'(1);
        pwm_cnt_d    = pwm_cnt_q;
        frame_tick_s = 1'b0;
        if (first_q) begin
            state_d      = BLANK;
            digit_idx_d  = 3'd0;
            slot_cnt_d   = {SLOT_W{1'b0}};
            pwm_cnt_d    = 4'd0;
            frame_tick_s = 1'b1;
        end else begin
            case (state_q)
                BLANK: begin
                    if (slot_cnt_q == BLANK_LAST) begin
                        state_d   = DRIVE;
                        pwm_cnt_d = 4'd0;
                    end else begin
                        state_d   = BLANK;
                    end
                end
                DRIVE: begin
                    pwm_cnt_d = pwm_cnt_q + 4'd1;
                    if (slot_cnt_q == SLOT_LAST) begin
                        state_d    = BLANK;
                        slot_cnt_d = {SLOT_W{1'b0}};
                        if (digit_idx_q == LAST_DIGIT) begin
                            digit_idx_d  = 3'd0;
                            frame_tick_s = 1'b1;
                        end else begin
                            digit_idx_d  = digit_idx_q + 3'd1;
                        end
                    end else begin
                        state_d = DRIVE;
                    end
                end
                default: begin
                    state_d     = BLANK;
                    digit_idx_d = 3'd0;
                    slot_cnt_d  = {SLOT_W{1'b0}};
                end
            endcase
        end
    end

    // Output decode from the next state so outputs move with the state
    always_comb begin
        case (digit_idx_d)
            3'd0:    shadow_sel_s = shadow_q[0];
            3'd1:    shadow_sel_s = shadow_q[1];
            3'd2:    shadow_sel_s = shadow_q[2];
            3'd3:    shadow_sel_s = shadow_q[3];
            3'd4:    shadow_sel_s = shadow_q[4];
            3'd5:    shadow_sel_s = shadow_q[5];
            default: shadow_sel_s = SEG_OFF;
        endcase
        lit_s = (state_d == DRIVE) && disp_en_sh_q &&
                (pwm_cnt_d <= brightness_sh_q) &&
                !(blink_phase_s && blink_mask_sh_q[digit_idx_d]);
        if (lit_s) begin
            seg_out_d  = shadow_sel_s;
            dig_en_n_d = digit_enable_n(digit_idx_d);
        end else begin
            seg_out_d  = SEG_OFF;
            dig_en_n_d = DIG_OFF;
        end
    end

    // Scan state, frame snapshot and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= BLANK;
            digit_idx_q     <= 3'd0;
            slot_cnt_q      <= {SLOT_W{1'b0}};
            pwm_cnt_q       <= 4'd0;
            first_q         <= 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= SEG_OFF;
            end
            disp_en_sh_q    <= 1'b0;
            brightness_sh_q <= 4'd0;
            blink_mask_sh_q <= 6'd0;
            seg_out_q       <= SEG_OFF;
            dig_en_n_q      <= DIG_OFF;
            frame_start_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            digit_idx_q   <= digit_idx_d;
            slot_cnt_q    <= slot_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            first_q       <= 1'b0;
            if (frame_tick_s) begin
                shadow_q[0]     <= seg_in0;
                shadow_q[1]     <= seg_in1;
                shadow_q[2]     <= seg_in2;
                shadow_q[3]     <= seg_in3;
                shadow_q[4]     <= seg_in4;
                shadow_q[5]     <= seg_in5;
                disp_en_sh_q    <= disp_en;
                brightness_sh_q <= brightness;
                blink_mask_sh_q <= blink_mask;
            end
            seg_out_q     <= seg_out_d;
            dig_en_n_q    <= dig_en_n_d;
            frame_start_q <= frame_tick_s;
        end
    end

    assign seg_out     = seg_out_q;
    assign dig_en_n    = dig_en_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: stimulus pushes per-slot expectations
// for each frame; a negedge monitor aligns to frame_start and checks them.
module tb_seg_scan_mux;

    localparam int DWELL     = 12;
    localparam int BLANK_CYC = 2;
    localparam int FRAME_LEN = 72;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] seg_in [6];
    logic       disp_en;
    logic [3:0] brightness;
    logic [5:0] blink_mask;
    logic [6:0] seg_out;
    logic [5:0] dig_en_n;
    logic       frame_start;

    seg_scan_mux #(
        .CLK_HZ       (1200),
        .SCAN_HZ      (100),
        .BLANK_CYCLES (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_in0     (seg_in[0]),
        .seg_in1     (seg_in[1]),
        .seg_in2     (seg_in[2]),
        .seg_in3     (seg_in[3]),
        .seg_in4     (seg_in[4]),
        .seg_in5     (seg_in[5]),
        .disp_en     (disp_en),
        .brightness  (brightness),
        .blink_mask  (blink_mask),
        .seg_out     (seg_out),
        .dig_en_n    (dig_en_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        int         on;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected lit cycles per slot: pwm runs 0..9 in the 10-cycle DRIVE,
    // lit while pwm <= brightness; blink phase for frame n is (n/2)%2
    task automatic push_frame(input int fno);
        exp_t e;
        bit   ph;
        bit   lit;
        ph = ((fno / 2) % 2) == 1;
        for (int i = 0; i < 6; i++) begin
            lit   = disp_en && !(ph && blink_mask[i]);
            e.seg = seg_in[i];
            e.on  = lit ? ((brightness >= 4'd9) ? 10 : int'(brightness) + 1) : 0;
            exp_q.push_back(e);
        end
    endtask

    // Wait for the next frame_start pulse; lat = cycles waited, 0 on timeout
    task automatic wait_fs(output int lat);
        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (frame_start) begin
                lat = c;
                break;
            end
        end
    endtask

    // Monitor state
    int         k;
    int         slot;
    int         off;
    int         on_cnt;
    int         first_on;
    int         err;
    bit         synced = 1'b0;
    bit         cur_valid = 1'b0;
    exp_t       cur;
    logic [5:0] one6 = 6'b000001;
    logic [5:0] want_dig;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            synced = 1'b0;
        end else begin
            if (synced) k++;
            if (frame_start) begin
                if (synced) check("frame_period", k, FRAME_LEN);
                k      = 0;
                synced = 1'b1;
            end else if (synced && k >= FRAME_LEN) begin
                check("frame_start_overdue", k, FRAME_LEN - 1);
                synced = 1'b0;
            end
            if (synced) begin
                slot     = k / DWELL;
                off      = k % DWELL;
                want_dig = ~(one6 << slot);
                if (off == 0) begin
                    on_cnt    = 0;
                    first_on  = -1;
                    err       = 0;
                    cur_valid = 1'b0;
                    if (exp_q.size() != 0) begin
                        cur       = exp_q.pop_front();
                        cur_valid = 1'b1;
                    end else if (!done) begin
                        check("exp_queue_depth", exp_q.size(), 1);
                    end
                end
                if (off < BLANK_CYC) begin
                    if (dig_en_n != 6'h3F || seg_out != 7'h7F) err++;
                end else if (dig_en_n == want_dig) begin
                    on_cnt++;
                    if (first_on < 0) first_on = off;
                    if (seg_out != cur.seg) err++;
                end else if (dig_en_n == 6'h3F) begin
                    if (seg_out != 7'h7F) err++;
                end else begin
                    err++;
                end
                if (off == DWELL - 1 && cur_valid) begin
                    check($sformatf("slot%0d_on_cycles", slot), on_cnt, cur.on);
                    if (cur.on > 0) check($sformatf("slot%0d_first_on", slot), first_on, BLANK_CYC);
                    check($sformatf("slot%0d_bus_errors", slot), err, 0);
                end
            end
        end
    end

    // Per-frame settings applied during frame f-1 (index = frame number)
    logic [3:0] tab_b [2:13];
    logic [5:0] tab_m [2:13];
    logic       tab_e [2:13];

    initial begin
        int lat;
        tab_b = '{4'd15, 4'd3, 4'd0, 4'd15, 4'd15, 4'd15, 4'd8, 4'd15, 4'd15, 4'd7, 4'd9, 4'd9};
        tab_m = '{6'b000000, 6'b000000, 6'b000000, 6'b000011, 6'b000011, 6'b000011,
                  6'b000011, 6'b000011, 6'b000000, 6'b000000, 6'b100100, 6'b100100};
        tab_e = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        seg_in[0] = 7'h40; seg_in[1] = 7'h79; seg_in[2] = 7'h24;
        seg_in[3] = 7'h30; seg_in[4] = 7'h19; seg_in[5] = 7'h12;
        disp_en = 1'b1; brightness = 4'd15; blink_mask = 6'b000000;
        reset = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_seg_out", int'(seg_out), 'h7F);
        check("reset_dig_en_n", int'(dig_en_n), 'h3F);
        check("reset_frame_start", int'(frame_start), 0);

        push_frame(1);
        reset = 1'b1;
        wait_fs(lat);
        check("first_frame_start_latency", lat, 1);

        for (int f = 1; f <= 12; f++) begin
            if (f > 1) begin
                wait_fs(lat);
                check("frame_start_gap", lat, FRAME_LEN - 17);
            end
            repeat (17) @(posedge clk);
            #1;
            if (f + 1 == 2) seg_in[2] = 7'h02;
            brightness = tab_b[f + 1];
            blink_mask = tab_m[f + 1];
            disp_en    = tab_e[f + 1];
            push_frame(f + 1);
        end

        wait_fs(lat);
        check("frame_start_gap", lat, FRAME_LEN - 17);
        repeat (3 * DWELL + 5) @(posedge clk);
        #1;
        check("pre_reset_digit3_enable", int'(dig_en_n), 'h37);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_seg_out", int'(seg_out), 'h7F);
        check("midreset_dig_en_n", int'(dig_en_n), 'h3F);
        check("midreset_frame_start", int'(frame_start), 0);
        @(posedge clk);
        #1;

        brightness = 4'd5;
        blink_mask = 6'b010000;
        disp_en    = 1'b1;
        push_frame(1);
        reset = 1'b1;
        wait_fs(lat);
        check("restart_frame_start_latency", lat, 1);
        repeat (17) @(posedge clk);
        #1;
        brightness = 4'd12;
        push_frame(2);
        done = 1'b1;
        wait_fs(lat);
        check("frame_start_gap", lat, FRAME_LEN - 17);
        repeat (FRAME_LEN + 2) @(posedge clk);
        #1;
        check("exp_queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
